// File: rtl/fft_pkg.sv
// Shared FFT controller definitions: FSM state encoding, pipeline latencies, bit reversal.
// The UNLOAD state exists only when FFT_CTRL_BITREV_UNLOAD_EN is defined.
package fft_pkg;

    `ifdef FFT_CTRL_BITREV_UNLOAD_EN
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, UNLOAD} fft_state_e;
    `else
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE} fft_state_e;
    `endif

    localparam int unsigned BF_LAT     = 1;
    localparam int unsigned MEM_RD_LAT = 1;
    localparam int unsigned DRAIN_CYC  = BF_LAT + MEM_RD_LAT;

    // Reverses the low w bits of x; bits at and above w come back as zero.
    function automatic logic [9:0] bit_rev(input logic [9:0] x, input int unsigned w);
        logic [9:0] r;
        r = '0;
        for (int unsigned i = 0; i < w; i++) begin
            r[i] = x[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_ctrl_if.sv
// Control/address bundle between the FFT controller and its memory/butterfly datapath.
// out_valid/out_index are present only with FFT_CTRL_BITREV_UNLOAD_EN.
interface fft_ctrl_if #(parameter int unsigned LOG2N = 5);

    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic             bf_enable;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;
    logic [3:0]       stage;
    `ifdef FFT_CTRL_BITREV_UNLOAD_EN
    logic             out_valid;
    logic [LOG2N-1:0] out_index;

    modport master (
        input  start,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_enable, wr_en, wr_addr_a, wr_addr_b, stage,
               out_valid, out_index
    );
    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_enable, wr_en, wr_addr_a, wr_addr_b, stage,
               out_valid, out_index
    );
    `else
    modport master (
        input  start,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_enable, wr_en, wr_addr_a, wr_addr_b, stage
    );
    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_enable, wr_en, wr_addr_a, wr_addr_b, stage
    );
    `endif

endinterface

// File: rtl/fft_addr_gen.sv
// Combinational radix-2 DIF address generator: butterfly index k and stage s
// map to input addresses a, b = a + h and twiddle index, where h = N >> (s+1).
module fft_addr_gen #(
    parameter int unsigned LOG2N = 5
) (
    input  logic [LOG2N-2:0] k,
    input  logic [3:0]       s,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw
);

    logic [31:0] h;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] a;

    // h is a power of two, so k/h and k%h are a mask split of k.
    always_comb begin
        h      = (32'd1 << LOG2N) >> (32'(s) + 32'd1);
        lo     = 32'(k) & (h - 32'd1);
        hi     = 32'(k) & ~(h - 32'd1);
        a      = (hi << 1) | lo;
        addr_a = LOG2N'(a);
        addr_b = LOG2N'(a | h);
        tw     = (LOG2N-1)'(lo << s);
    end

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIF FFT sequencer: per-stage read/butterfly/write schedule.
// FFT_CTRL_BITREV_UNLOAD_EN adds a bit-reversed readout phase (UNLOAD).
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = 5
) (
    input  logic      clk,
    input  logic      rst,
    fft_ctrl_if.master bus
);

    localparam int unsigned N    = 1 << LOG2N;
    localparam int unsigned HALF = N / 2;
    localparam int unsigned CW   = LOG2N + 1;

    fft_state_e state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       s_q, s_d;

    logic             rv1_q, rv1_d, rv2_q, rv2_d;
    logic [LOG2N-1:0] ra1_q, ra1_d, rb1_q, rb1_d;
    logic [LOG2N-1:0] ra2_q, ra2_d, rb2_q, rb2_d;

    logic             busy_c, done_c, rd_en_c, run_rd;
    logic [LOG2N-1:0] rd_a, rd_b;
    logic [LOG2N-2:0] tw_c;
    logic [LOG2N-1:0] ag_a, ag_b;
    logic [LOG2N-2:0] ag_tw;

    `ifdef FFT_CTRL_BITREV_UNLOAD_EN
    logic             unl_rd;
    logic             uv1_q, uv1_d;
    logic [LOG2N-1:0] ui1_q, ui1_d;
    `endif

    fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
        .k      (cnt_q[LOG2N-2:0]),
        .s      (s_q),
        .addr_a (ag_a),
        .addr_b (ag_b),
        .tw     (ag_tw)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        rd_en_c = 1'b0;
        run_rd  = 1'b0;
        rd_a    = '0;
        rd_b    = '0;
        tw_c    = '0;
        `ifdef FFT_CTRL_BITREV_UNLOAD_EN
        unl_rd  = 1'b0;
        `endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    s_d     = '0;
                end
            end
            RUN: begin
                busy_c  = 1'b1;
                rd_en_c = 1'b1;
                run_rd  = 1'b1;
                rd_a    = ag_a;
                rd_b    = ag_b;
                tw_c    = ag_tw;
                if (cnt_q == CW'(HALF - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                busy_c = 1'b1;
                if (cnt_q == CW'(DRAIN_CYC - 1)) begin
                    cnt_d = '0;
                    if (s_q < 4'(LOG2N - 1)) begin
                        s_d     = s_q + 1'b1;
                        state_d = RUN;
                    end else begin
                        `ifdef FFT_CTRL_BITREV_UNLOAD_EN
                        state_d = UNLOAD;
                        `else
                        state_d = DONE;
                        `endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            `ifdef FFT_CTRL_BITREV_UNLOAD_EN
            // cnt runs 0..N: N reads, then one cycle for the final out_valid.
            UNLOAD: begin
                busy_c = 1'b1;
                if (cnt_q == CW'(N)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    rd_en_c = 1'b1;
                    unl_rd  = 1'b1;
                    rd_a    = LOG2N'(bit_rev(10'(cnt_q), LOG2N));
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            `endif
            DONE: begin
                done_c  = 1'b1;
                s_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rv1_d = run_rd;
        ra1_d = run_rd ? rd_a : '0;
        rb1_d = run_rd ? rd_b : '0;
        rv2_d = rv1_q;
        ra2_d = ra1_q;
        rb2_d = rb1_q;
        `ifdef FFT_CTRL_BITREV_UNLOAD_EN
        uv1_d = unl_rd;
        ui1_d = unl_rd ? LOG2N'(cnt_q) : '0;
        `endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            rv1_q   <= 1'b0;
            ra1_q   <= '0;
            rb1_q   <= '0;
            rv2_q   <= 1'b0;
            ra2_q   <= '0;
            rb2_q   <= '0;
            `ifdef FFT_CTRL_BITREV_UNLOAD_EN
            uv1_q   <= 1'b0;
            ui1_q   <= '0;
            `endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            rv1_q   <= rv1_d;
            ra1_q   <= ra1_d;
            rb1_q   <= rb1_d;
            rv2_q   <= rv2_d;
            ra2_q   <= ra2_d;
            rb2_q   <= rb2_d;
            `ifdef FFT_CTRL_BITREV_UNLOAD_EN
            uv1_q   <= uv1_d;
            ui1_q   <= ui1_d;
            `endif
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.rd_en     = rd_en_c;
    assign bus.rd_addr_a = rd_a;
    assign bus.rd_addr_b = rd_b;
    assign bus.tw_addr   = tw_c;
    assign bus.bf_enable = rv1_q;
    assign bus.wr_en     = rv2_q;
    assign bus.wr_addr_a = ra2_q;
    assign bus.wr_addr_b = rb2_q;
    assign bus.stage     = s_q;
    `ifdef FFT_CTRL_BITREV_UNLOAD_EN
    assign bus.out_valid = uv1_q;
    assign bus.out_index = ui1_q;
    `endif

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed table-driven bench for fft_ctrl at LOG2N=3 (N=8); the expected
// schedule is built from hand-computed butterfly rows plus the bit-reversed unload order.
module tb_fft_ctrl;

    localparam int unsigned LOG2N = 3;
    `ifdef FFT_CTRL_BITREV_UNLOAD_EN
    localparam int DONE_CYC = 28;
    `else
    localparam int DONE_CYC = 19;
    `endif
    localparam int NCAP = DONE_CYC + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_ctrl_if #(.LOG2N(LOG2N)) bus ();
    fft_ctrl #(.LOG2N(LOG2N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int cyc;
        int stg;
        int a;
        int b;
        int tw;
    } vec_t;

    vec_t vecs[12];
    int   unl_seq[8];

    int exp_busy[0:NCAP+2];
    int exp_done[0:NCAP+2];
    int exp_rd  [0:NCAP+2];
    int exp_bf  [0:NCAP+2];
    int exp_wr  [0:NCAP+2];
    int exp_run [0:NCAP+2];
    int exp_a   [0:NCAP+2];
    int exp_b   [0:NCAP+2];
    int exp_tw  [0:NCAP+2];
    int exp_stg [0:NCAP+2];
    int exp_wa  [0:NCAP+2];
    int exp_wb  [0:NCAP+2];
    int exp_ov  [0:NCAP+2];
    int exp_oi  [0:NCAP+2];

    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  0, 32'(bus.busy),      32'd0);
        chk({tag, "_done"},  0, 32'(bus.done),      32'd0);
        chk({tag, "_rd_en"}, 0, 32'(bus.rd_en),     32'd0);
        chk({tag, "_rd_a"},  0, 32'(bus.rd_addr_a), 32'd0);
        chk({tag, "_rd_b"},  0, 32'(bus.rd_addr_b), 32'd0);
        chk({tag, "_tw"},    0, 32'(bus.tw_addr),   32'd0);
        chk({tag, "_bf"},    0, 32'(bus.bf_enable), 32'd0);
        chk({tag, "_wr_en"}, 0, 32'(bus.wr_en),     32'd0);
        chk({tag, "_wr_a"},  0, 32'(bus.wr_addr_a), 32'd0);
        chk({tag, "_wr_b"},  0, 32'(bus.wr_addr_b), 32'd0);
        chk({tag, "_stage"}, 0, 32'(bus.stage),     32'd0);
        `ifdef FFT_CTRL_BITREV_UNLOAD_EN
        chk({tag, "_ov"},    0, 32'(bus.out_valid), 32'd0);
        chk({tag, "_oi"},    0, 32'(bus.out_index), 32'd0);
        `endif
    endtask

    task automatic build_expected();
        for (int c = 0; c <= NCAP + 2; c++) begin
            exp_busy[c] = (c >= 1 && c < DONE_CYC) ? 1 : 0;
            exp_done[c] = (c == DONE_CYC) ? 1 : 0;
            exp_rd[c] = 0; exp_bf[c] = 0; exp_wr[c] = 0; exp_run[c] = 0;
            exp_a[c] = 0; exp_b[c] = 0; exp_tw[c] = 0; exp_stg[c] = 0;
            exp_wa[c] = 0; exp_wb[c] = 0; exp_ov[c] = 0; exp_oi[c] = 0;
        end
        for (int i = 0; i < 12; i++) begin
            exp_rd[vecs[i].cyc]     = 1;
            exp_run[vecs[i].cyc]    = 1;
            exp_a[vecs[i].cyc]      = vecs[i].a;
            exp_b[vecs[i].cyc]      = vecs[i].b;
            exp_tw[vecs[i].cyc]     = vecs[i].tw;
            exp_stg[vecs[i].cyc]    = vecs[i].stg;
            exp_bf[vecs[i].cyc + 1] = 1;
            exp_wr[vecs[i].cyc + 2] = 1;
            exp_wa[vecs[i].cyc + 2] = vecs[i].a;
            exp_wb[vecs[i].cyc + 2] = vecs[i].b;
        end
        for (int i = 0; i < 8; i++) begin
            exp_rd[19 + i] = 1;
            exp_a[19 + i]  = unl_seq[i];
            exp_ov[20 + i] = 1;
            exp_oi[20 + i] = i;
        end
        `ifndef FFT_CTRL_BITREV_UNLOAD_EN
        for (int c = 19; c <= NCAP + 2; c++) begin
            exp_rd[c] = 0; exp_a[c] = 0; exp_ov[c] = 0; exp_oi[c] = 0;
        end
        `endif
    endtask

    // Caller leaves the DUT idle; start is pulsed here, and optionally again at cycle inj.
    task automatic run_and_check(input string tag, input int inj);
        bus.start = 1'b1;
        for (int c = 1; c <= NCAP; c++) begin
            tick();
            bus.start = (c == inj) ? 1'b1 : 1'b0;
            chk({tag, "_busy"},  c, 32'(bus.busy),      32'(exp_busy[c]));
            chk({tag, "_done"},  c, 32'(bus.done),      32'(exp_done[c]));
            chk({tag, "_rd_en"}, c, 32'(bus.rd_en),     32'(exp_rd[c]));
            chk({tag, "_bf"},    c, 32'(bus.bf_enable), 32'(exp_bf[c]));
            chk({tag, "_wr_en"}, c, 32'(bus.wr_en),     32'(exp_wr[c]));
            if (exp_rd[c] != 0) begin
                chk({tag, "_rd_a"}, c, 32'(bus.rd_addr_a), 32'(exp_a[c]));
            end
            if (exp_run[c] != 0) begin
                chk({tag, "_rd_b"},  c, 32'(bus.rd_addr_b), 32'(exp_b[c]));
                chk({tag, "_tw"},    c, 32'(bus.tw_addr),   32'(exp_tw[c]));
                chk({tag, "_stage"}, c, 32'(bus.stage),     32'(exp_stg[c]));
            end
            if (exp_wr[c] != 0) begin
                chk({tag, "_wr_a"}, c, 32'(bus.wr_addr_a), 32'(exp_wa[c]));
                chk({tag, "_wr_b"}, c, 32'(bus.wr_addr_b), 32'(exp_wb[c]));
            end
            `ifdef FFT_CTRL_BITREV_UNLOAD_EN
            chk({tag, "_ov"}, c, 32'(bus.out_valid), 32'(exp_ov[c]));
            if (exp_ov[c] != 0) begin
                chk({tag, "_oi"}, c, 32'(bus.out_index), 32'(exp_oi[c]));
            end
            `endif
        end
    endtask

    initial begin
        // {cycle after start, stage, a, b, tw}
        vecs[0]  = '{1,  0, 0, 4, 0};
        vecs[1]  = '{2,  0, 1, 5, 1};
        vecs[2]  = '{3,  0, 2, 6, 2};
        vecs[3]  = '{4,  0, 3, 7, 3};
        vecs[4]  = '{7,  1, 0, 2, 0};
        vecs[5]  = '{8,  1, 1, 3, 2};
        vecs[6]  = '{9,  1, 4, 6, 0};
        vecs[7]  = '{10, 1, 5, 7, 2};
        vecs[8]  = '{13, 2, 0, 1, 0};
        vecs[9]  = '{14, 2, 2, 3, 0};
        vecs[10] = '{15, 2, 4, 5, 0};
        vecs[11] = '{16, 2, 6, 7, 0};
        unl_seq  = '{0, 4, 2, 6, 1, 5, 3, 7};
        build_expected();

        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");

        // rst wins over a simultaneous start
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_all_zero("rst_prio");
        rst = 1'b0;
        repeat (2) tick();
        check_all_zero("idle");

        run_and_check("run1", -1);
        repeat (2) tick();

        run_and_check("ign_start", 5);
        repeat (2) tick();

        // reset while in stage 1, then a fresh full run
        bus.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.start = 1'b0;
        end
        chk("mid_stage_before_rst", 8, 32'(bus.stage), 32'd1);
        rst = 1'b1;
        tick();
        check_all_zero("mid_rst");
        rst = 1'b0;
        repeat (2) tick();
        check_all_zero("post_rst_idle");
        run_and_check("run_after_rst", -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 SHALL have parameter LOG2N, default 5, meaning log2 of the FFT size N; legal values are 2 to 10.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: single-cycle request to start an in-place DIF transform.
REQ-005 SHALL have port busy, output, 1 bit: high while the transform is in progress.
REQ-006 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-007 SHALL have port rd_en, output, 1 bit: sample-memory read strobe; the memory returns data one cycle later.
REQ-008 SHALL have ports rd_addr_a and rd_addr_b, output, LOG2N bits each: read addresses of butterfly inputs a and b.
REQ-009 SHALL have port tw_addr, output, LOG2N-1 bits: twiddle ROM address m, selecting W = exp(-j2πm/N).
REQ-010 SHALL have port bf_enable, output, 1 bit: drives the butterfly enable; the butterfly output appears one cycle later.
REQ-011 SHALL have port wr_en, output, 1 bit: sample-memory write strobe.
REQ-012 SHALL have ports wr_addr_a and wr_addr_b, output, LOG2N bits each: write addresses for the Xa and Xb results.
REQ-013 SHALL have port stage, output, 4 bits: current stage index s.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN and DONE, plus UNLOAD when the option in REQ-030 is enabled.
REQ-015 SHALL accept start only in IDLE, and SHALL ignore start in every other state.
REQ-016 SHALL, for an accepted start, enter RUN on the next cycle with s=0 and k=0.
REQ-017 SHALL, in each RUN cycle, assert rd_en with rd_addr_a, rd_addr_b and tw_addr computed from butterfly index k (0..N/2-1) and stage s as follows:
- h = N>>(s+1);
- rd_addr_a = (k/h)*2h + k%h;
- rd_addr_b = rd_addr_a + h;
- tw_addr = (k%h)<<s.
REQ-018 SHALL increment k once per RUN cycle, and SHALL enter DRAIN after the cycle in which k = N/2-1 is issued.
REQ-019 SHALL assert bf_enable exactly one cycle after each rd_en.
REQ-020 SHALL assert wr_en two cycles after the corresponding rd_en, with wr_addr_a and wr_addr_b equal to the read addresses delayed by two cycles.
REQ-021 SHALL hold DRAIN for exactly 2 cycles so that every write of stage s completes before any read of stage s+1 is issued.
REQ-022 SHALL, at the end of DRAIN:
- if s < LOG2N-1, increment s, reset k to 0 and enter RUN;
- otherwise enter DONE, or UNLOAD when it is enabled.
REQ-023 SHALL hold DONE for 1 cycle with done=1, then return to IDLE.
REQ-024 SHALL drive busy=1 in RUN, DRAIN and UNLOAD, and busy=0 in IDLE and DONE.
REQ-025 SHALL drive rd_en, bf_enable and wr_en low in every cycle not defined above.
REQ-026 SHALL have a total latency of LOG2N*(N/2+2) busy cycles, with done in the following cycle; for the default N=32 this is 90 busy cycles with done in cycle 91.

Reset
REQ-027 SHALL, when rst=1, force the state to IDLE and clear k, s and both delay pipelines.
REQ-028 SHALL drive all outputs to 0 in the cycle after rst is asserted, including when rst is asserted mid-transform.
REQ-029 SHALL give rst priority over start in the same cycle.

Configuration
REQ-030 SHALL provide macro FFT_CTRL_BITREV_UNLOAD_EN, which adds output ports out_valid (1 bit) and out_index (LOG2N bits).
REQ-031 SHALL, with FFT_CTRL_BITREV_UNLOAD_EN defined, add UNLOAD after the final DRAIN, behaving as follows:
- for i = 0..N-1, assert rd_en with rd_addr_a = bit-reverse(i);
- assert out_valid one cycle later with out_index = i;
- after the last out_valid, enter DONE;
- busy is extended by N+1 cycles.
REQ-032 SHALL, without FFT_CTRL_BITREV_UNLOAD_EN, omit the UNLOAD state, out_valid and out_index, and behave exactly as REQ-014 to REQ-026.

Structure
REQ-033 SHALL take the following from shared package fft_pkg:
- the FSM state enum;
- BF_LAT = 1;
- MEM_RD_LAT = 1;
- DRAIN_CYC = BF_LAT + MEM_RD_LAT.
REQ-034 SHALL place address generation (k, s -> a, b, tw) in combinational sub-module fft_addr_gen.

Verification
REQ-035 SHALL verify, with LOG2N=3, start in stage 0: k=0 -> a=0, b=4, tw=0; k=3 -> a=3, b=7, tw=3.
REQ-036 SHALL verify, with LOG2N=3, stage 1: k=1 -> a=1, b=3, tw=2; k=2 -> a=4, b=6, tw=0. Stage 2: k=3 -> a=6, b=7, tw=0.
REQ-037 SHALL verify, with LOG2N=3, that busy lasts 18 cycles and done pulses once in cycle 19, and that wr_en trails rd_en by exactly 2 cycles throughout.
REQ-038 SHALL verify that a start issued while busy is ignored, and that completion still occurs at the original cycle with no second done.
REQ-039 SHALL verify that rst asserted in stage 1 drives all outputs to 0 on the next cycle, and that a later start yields a full, correct run.
REQ-040 SHALL verify, with FFT_CTRL_BITREV_UNLOAD_EN defined and LOG2N=3, that UNLOAD rd_addr_a follows the sequence 0,4,2,6,1,5,3,7 and out_index follows 0..7 one cycle behind.
